data_mem_ws: RTL and testbench
==============================

DATA_MEM_WS -- requirements
Module: data_mem_ws

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, number of 32-bit words (power of two, 16..65536).
REQ-002 Parameter ADDR_BASE, default 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned).
REQ-003 Parameter WAIT_STATES, default 1, extra access cycles (0..7).
REQ-004 Parameter CLEAR_ON_RESET, default 1, 1 = zero whole array after reset, 0 = skip clear.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 req  in  1  access request, sampled only when ready=1.
REQ-008 we  in  1  1 = store, 0 = load.
REQ-009 size  in  3  000 word; 001 signed half; 010 unsigned half; 011 signed byte; 100 unsigned byte; stores treat 001/010 as half, 011/100 as byte.
REQ-010 addr  in  32  byte address.
REQ-011 wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 pc  in  32  instruction address, trace only.
REQ-013 ready  out  1  block idle, accepting req.
REQ-014 rvalid  out  1  one-cycle completion pulse.
REQ-015 rdata  out  32  load result, valid while rvalid=1, held otherwise.
REQ-016 fault  out  1  asserted with rvalid when access rejected.
REQ-017 busy  out  1  high in CLEAR, WAIT, RESP.

Function
REQ-018 FSM states CLEAR, IDLE, WAIT, RESP; ready=1 only in IDLE.
REQ-019 CLEAR: one word zeroed per cycle, index 0..DEPTH_WORDS-1; after last index -> IDLE; duration exactly DEPTH_WORDS cycles.
REQ-020 IDLE with req=1: latch we/size/addr/wdata/pc; -> WAIT (counter=WAIT_STATES) if WAIT_STATES>0, else -> RESP.
REQ-021 WAIT: counter decrements each cycle; counter==1 -> RESP.
REQ-022 Edge entering RESP: store committed and rdata registered; RESP lasts one cycle with rvalid=1, then -> IDLE.
REQ-023 Latency: rvalid high in cycle WAIT_STATES+1 after accept edge; max throughput one access per WAIT_STATES+2 cycles.
REQ-024 req while ready=0 ignored, not queued.
REQ-025 Fault if: size 101..111; word with addr[1:0]!=0; half with addr[0]=1; addr<ADDR_BASE or addr>=ADDR_BASE+4*DEPTH_WORDS.
REQ-026 Faulted access: no memory write, rdata=0, fault=1 for RESP cycle only.
REQ-027 Word index = (addr-ADDR_BASE)[..:2]; only in-range indices touch array.
REQ-028 Stores: byte-lane merge; half writes lanes per addr[1], byte writes lane addr[1:0]; other lanes preserved.
REQ-029 Loads: lane selected by addr[1:0]/addr[1]; signed modes sign-extend lane MSB, unsigned zero-extend; word returns full word.
REQ-030 Load result reflects all previously committed stores (no stale read).
REQ-031 Simulation-only: each committed store prints "time@pc: *word_addr <= merged_word"; no print on fault.

Reset
REQ-032 reset=1 at any time: immediately ready=0, rvalid=0, fault=0, rdata=0, counter=0, clear index=0; pending access abandoned, no write.
REQ-033 Release: state CLEAR if CLEAR_ON_RESET=1 (busy=1), else IDLE (busy=0); array contents undefined when CLEAR_ON_RESET=0 except simulation initial zero.

Verification
REQ-034 DEPTH_WORDS=16, CLEAR_ON_RESET=1: release reset -> busy=1, ready=0 for 16 cycles, then ready=1; lw 0x0 -> rdata=0, fault=0.
REQ-035 WAIT_STATES=2: sw 0x12345678 @0x10; lb @0x13 -> 0x00000012; lh @0x12 -> 0x00001234; rvalid exactly 3 cycles after accept edge.
REQ-036 sw 0x11223344 @0x20; sb 0x000000AB @0x21 -> word 0x1122AB44; lb @0x21 -> 0xFFFFFFAB; lbu @0x21 -> 0x000000AB; lhu @0x22 -> 0x00001122.
REQ-037 lw @0x22 -> rvalid=1, fault=1, rdata=0; sw @0x22 -> word 0x20 unchanged; lw @0x4000 with DEPTH_WORDS=4096 -> fault=1; size=101 -> fault=1.
REQ-038 sw 0xDEADBEEF @0x8, reset asserted in WAIT -> no rvalid pulse; after clear lw @0x8 -> 0x00000000.
REQ-039 req held high, WAIT_STATES=0 -> accepts every 2nd cycle, rvalid alternates 0/1, each completion matches its request order.

Source files
------------

// File: rtl/data_mem_ws.sv
// data_mem_ws: single-port word-organised data memory with a programmable
// number of wait states, byte/half/word loads and stores, and a power-up
// clear sequence.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-high
//   req        access request, taken only while ready=1
//   we         1 = store, 0 = load
//   size       000 word, 001 signed half, 010 unsigned half,
//              011 signed byte, 100 unsigned byte (stores ignore signedness)
//   addr       byte address
//   wdata      store data, right-aligned
//   pc         instruction address of the access (trace only)
//   ready      idle and accepting a request
//   rvalid     one-cycle completion pulse
//   rdata      load result while rvalid=1, held otherwise (0 for stores/faults)
//   fault      rejected access, coincides with rvalid
//   busy       clearing, waiting or responding
//   dbg_state  current FSM state (CLEAR=0, IDLE=1, WAIT=2, RESP=3)
//   dbg_pc     pc of the most recently accepted access
//
// Handshake: a request is accepted on a rising edge where req=1 and ready=1;
// req while ready=0 is dropped, never queued. Every accepted request yields
// exactly one rvalid pulse WAIT_STATES+1 cycles after the accept edge, unless
// reset intervenes, in which case the access is abandoned with no write.
module data_mem_ws #(
  parameter int unsigned DEPTH_WORDS    = 4096,
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int unsigned WAIT_STATES    = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        busy,
  output logic [1:0]  dbg_state,
  output logic [31:0] dbg_pc
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  WS      = 3'(WAIT_STATES);
  localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) << 2;

  localparam logic [1:0]  S_CLEAR = 2'd0;
  localparam logic [1:0]  S_IDLE  = 2'd1;
  localparam logic [1:0]  S_WAIT  = 2'd2;
  localparam logic [1:0]  S_RESP  = 2'd3;
  localparam logic [1:0]  S_START = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  logic [1:0]    state;
  logic [2:0]    cnt;
  logic [AW-1:0] clear_idx;

  logic          we_q;
  logic [2:0]    size_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   pc_q;

  logic [31:0]   mem [DEPTH_WORDS];

  // The access being worked on: straight from the inputs while idle (needed
  // when WAIT_STATES=0 and the commit happens on the accept edge), otherwise
  // from the latched copy.
  logic          a_we;
  logic [2:0]    a_size;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;

  logic [32:0]   off;
  logic          in_range;
  logic          misaligned;
  logic          a_fault;
  logic [AW-1:0] idx;
  logic [31:0]   cur_word;
  logic [7:0]    byte_lane;
  logic [15:0]   half_lane;
  logic [31:0]   load_val;
  logic [31:0]   merged;

  logic          accept;
  logic          to_resp;
  logic          commit_wr;

  always_comb begin
    if (state == S_IDLE) begin
      a_we    = we;
      a_size  = size;
      a_addr  = addr;
      a_wdata = wdata;
    end else begin
      a_we    = we_q;
      a_size  = size_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  // 33-bit offset: an address below ADDR_BASE wraps to a value >= 2^32 and
  // therefore fails the single range compare.
  always_comb begin
    off      = {1'b0, a_addr} - {1'b0, ADDR_BASE};
    in_range = (off < SPAN);
    idx      = off[AW+1:2];
    case (a_size)
      3'd0:       misaligned = (a_addr[1:0] != 2'b00);
      3'd1, 3'd2: misaligned = a_addr[0];
      default:    misaligned = 1'b0;
    endcase
    a_fault = (a_size > 3'd4) | misaligned | ~in_range;
  end

  // Asynchronous array read so a load always sees the latest committed store.
  always_comb begin
    cur_word = mem[idx];
    case (a_addr[1:0])
      2'd0:    byte_lane = cur_word[7:0];
      2'd1:    byte_lane = cur_word[15:8];
      2'd2:    byte_lane = cur_word[23:16];
      default: byte_lane = cur_word[31:24];
    endcase
    half_lane = a_addr[1] ? cur_word[31:16] : cur_word[15:0];
    case (a_size)
      3'd0:    load_val = cur_word;
      3'd1:    load_val = {{16{half_lane[15]}}, half_lane};
      3'd2:    load_val = {16'h0000, half_lane};
      3'd3:    load_val = {{24{byte_lane[7]}}, byte_lane};
      3'd4:    load_val = {24'h000000, byte_lane};
      default: load_val = 32'h0000_0000;
    endcase
  end

  // Byte-lane merge of store data into the current word.
  always_comb begin
    merged = cur_word;
    case (a_size)
      3'd0: merged = a_wdata;
      3'd1, 3'd2: begin
        if (a_addr[1]) merged[31:16] = a_wdata[15:0];
        else           merged[15:0]  = a_wdata[15:0];
      end
      3'd3, 3'd4: begin
        case (a_addr[1:0])
          2'd0:    merged[7:0]   = a_wdata[7:0];
          2'd1:    merged[15:8]  = a_wdata[7:0];
          2'd2:    merged[23:16] = a_wdata[7:0];
          default: merged[31:24] = a_wdata[7:0];
        endcase
      end
      default: merged = cur_word;
    endcase
  end

  assign accept    = (state == S_IDLE) && req;
  assign to_resp   = (accept && (WS == 3'd0)) || ((state == S_WAIT) && (cnt == 3'd1));
  // reset is level-checked here too: an access caught by reset never writes.
  assign commit_wr = to_resp && a_we && !a_fault && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_START;
      cnt       <= 3'd0;
      clear_idx <= '0;
      rvalid    <= 1'b0;
      fault     <= 1'b0;
      rdata     <= 32'h0000_0000;
      we_q      <= 1'b0;
      size_q    <= 3'd0;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      pc_q      <= 32'h0000_0000;
    end else begin
      rvalid <= 1'b0;
      fault  <= 1'b0;
      case (state)
        S_CLEAR: begin
          clear_idx <= clear_idx + 1'b1;
          if (clear_idx == AW'(DEPTH_WORDS - 1)) state <= S_IDLE;
        end
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            pc_q    <= pc;
            if (WS != 3'd0) begin
              state <= S_WAIT;
              cnt   <= WS;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
      if (to_resp) begin
        rvalid <= 1'b1;
        fault  <= a_fault;
        rdata  <= (a_fault || a_we) ? 32'h0000_0000 : load_val;
      end
    end
  end

  // Array has no reset; it is zeroed by the CLEAR walk instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR)  mem[clear_idx] <= 32'h0000_0000;
      else if (commit_wr)    mem[idx]       <= merged;
    end
  end

  assign ready     = (state == S_IDLE) && !reset;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign dbg_pc    = pc_q;

endmodule

// File: tb/tb_data_mem_ws.sv
module tb_data_mem_ws;

  localparam int WS_A = 2;

  typedef struct {
    logic        w;
    logic [2:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ef;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_a = 1'b1;
  logic        reset_b = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  size = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] pc = 32'h1000;

  logic        ready_a, rvalid_a, fault_a, busy_a;
  logic [31:0] rdata_a, dbg_pc_a;
  logic [1:0]  dbg_state_a;
  logic        ready_b, rvalid_b, fault_b, busy_b;
  logic [31:0] rdata_b, dbg_pc_b;
  logic [1:0]  dbg_state_b;

  int checks = 0;
  int failures = 0;

  logic [32:0] exp_q_a[$];
  logic [32:0] exp_q_b[$];
  int          tag_q_a[$];
  int          tag_q_b[$];
  vec_t        tbl_a[$];
  vec_t        tbl_b[$];

  // clock / reset
  always #5 clk = ~clk;

  data_mem_ws #(.DEPTH_WORDS(16), .ADDR_BASE(32'h0), .WAIT_STATES(WS_A), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .reset(reset_a), .req(req_a), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .pc(pc), .ready(ready_a), .rvalid(rvalid_a), .rdata(rdata_a),
    .fault(fault_a), .busy(busy_a), .dbg_state(dbg_state_a), .dbg_pc(dbg_pc_a)
  );

  data_mem_ws #(.DEPTH_WORDS(4096), .ADDR_BASE(32'h0), .WAIT_STATES(0), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .reset(reset_b), .req(req_b), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .pc(pc), .ready(ready_b), .rvalid(rvalid_b), .rdata(rdata_b),
    .fault(fault_b), .busy(busy_b), .dbg_state(dbg_state_b), .dbg_pc(dbg_pc_b)
  );

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // scoreboard: every rvalid pulse pops one expected {fault, rdata}
  always @(negedge clk) begin
    if (rvalid_a) begin
      if (exp_q_a.size() == 0) check("a_unexpected_rvalid", 33'd1, 33'd0);
      else check($sformatf("a_resp%0d", tag_q_a.pop_front()), {fault_a, rdata_a}, exp_q_a.pop_front());
    end
    if (rvalid_b) begin
      if (exp_q_b.size() == 0) check("b_unexpected_rvalid", 33'd1, 33'd0);
      else check($sformatf("b_resp%0d", tag_q_b.pop_front()), {fault_b, rdata_b}, exp_q_b.pop_front());
    end
  end

  // driver: one access on dut_a, checks acceptance-to-rvalid latency
  task automatic access_a(input vec_t v, input int tag);
    int n;
    int lat;
    n = 0;
    while (!ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("a_ready_before%0d", tag), {32'd0, ready_a}, 33'd1);
    we = v.w; size = v.sz; addr = v.ad; wdata = v.wd; pc = pc + 32'd4;
    req_a = 1'b1;
    exp_q_a.push_back({v.ef, v.er});
    tag_q_a.push_back(tag);
    @(posedge clk);
    #1 req_a = 1'b0;
    lat = 1;
    while (!rvalid_a && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("a_latency%0d", tag), 33'(lat), 33'(WS_A + 1));
  endtask

  task automatic wait_ready_a(input int expect_cycles);
    int n;
    n = 0;
    while (!ready_a && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("a_clear_cycles", 33'(n), 33'(expect_cycles));
  endtask

  initial begin
    int n;
    // dut_a: DEPTH 16, 2 wait states
    tbl_a.push_back('{1'b0, 3'd0, 32'h00, 32'h0,        32'h0,        1'b0}); // lw 0 after clear
    tbl_a.push_back('{1'b1, 3'd0, 32'h10, 32'h12345678, 32'h0,        1'b0}); // sw
    tbl_a.push_back('{1'b0, 3'd3, 32'h13, 32'h0,        32'h00000012, 1'b0}); // lb
    tbl_a.push_back('{1'b0, 3'd1, 32'h12, 32'h0,        32'h00001234, 1'b0}); // lh
    tbl_a.push_back('{1'b0, 3'd0, 32'h10, 32'h0,        32'h12345678, 1'b0}); // lw
    tbl_a.push_back('{1'b1, 3'd0, 32'h20, 32'h11223344, 32'h0,        1'b0}); // sw
    tbl_a.push_back('{1'b1, 3'd3, 32'h21, 32'h000000AB, 32'h0,        1'b0}); // sb
    tbl_a.push_back('{1'b0, 3'd0, 32'h20, 32'h0,        32'h1122AB44, 1'b0}); // merged word
    tbl_a.push_back('{1'b0, 3'd3, 32'h21, 32'h0,        32'hFFFFFFAB, 1'b0}); // lb sign
    tbl_a.push_back('{1'b0, 3'd4, 32'h21, 32'h0,        32'h000000AB, 1'b0}); // lbu
    tbl_a.push_back('{1'b0, 3'd2, 32'h22, 32'h0,        32'h00001122, 1'b0}); // lhu
    tbl_a.push_back('{1'b0, 3'd0, 32'h22, 32'h0,        32'h0,        1'b1}); // lw misaligned
    tbl_a.push_back('{1'b1, 3'd0, 32'h22, 32'hFFFFFFFF, 32'h0,        1'b1}); // sw misaligned
    tbl_a.push_back('{1'b0, 3'd0, 32'h20, 32'h0,        32'h1122AB44, 1'b0}); // unchanged
    tbl_a.push_back('{1'b0, 3'd5, 32'h20, 32'h0,        32'h0,        1'b1}); // bad size
    tbl_a.push_back('{1'b0, 3'd1, 32'h21, 32'h0,        32'h0,        1'b1}); // half odd
    tbl_a.push_back('{1'b0, 3'd0, 32'h40, 32'h0,        32'h0,        1'b1}); // past end
    tbl_a.push_back('{1'b0, 3'd0, 32'h3C, 32'h0,        32'h0,        1'b0}); // last word
    tbl_a.push_back('{1'b1, 3'd2, 32'h3E, 32'hCAFE8001, 32'h0,        1'b0}); // sh upper
    tbl_a.push_back('{1'b0, 3'd0, 32'h3C, 32'h0,        32'h80010000, 1'b0});
    tbl_a.push_back('{1'b0, 3'd1, 32'h3E, 32'h0,        32'hFFFF8001, 1'b0}); // lh sign
    tbl_a.push_back('{1'b1, 3'd4, 32'h3C, 32'h1234565A, 32'h0,        1'b0}); // sb lane0
    tbl_a.push_back('{1'b0, 3'd0, 32'h3C, 32'h0,        32'h8001005A, 1'b0});
    tbl_a.push_back('{1'b1, 3'd0, 32'h08, 32'h0BADF00D, 32'h0,        1'b0});
    tbl_a.push_back('{1'b0, 3'd0, 32'h08, 32'h0,        32'h0BADF00D, 1'b0});

    // dut_b: DEPTH 4096, no wait states, req held high
    tbl_b.push_back('{1'b1, 3'd0, 32'h100,  32'hA5A5A5A5, 32'h0,        1'b0});
    tbl_b.push_back('{1'b0, 3'd0, 32'h100,  32'h0,        32'hA5A5A5A5, 1'b0});
    tbl_b.push_back('{1'b1, 3'd4, 32'h101,  32'h00000077, 32'h0,        1'b0});
    tbl_b.push_back('{1'b0, 3'd0, 32'h100,  32'h0,        32'hA5A577A5, 1'b0});
    tbl_b.push_back('{1'b0, 3'd0, 32'h4000, 32'h0,        32'h0,        1'b1});
    tbl_b.push_back('{1'b0, 3'd0, 32'h3FFC, 32'h0,        32'h0,        1'b0});
    tbl_b.push_back('{1'b1, 3'd1, 32'h3FFE, 32'h00001234, 32'h0,        1'b0});
    tbl_b.push_back('{1'b0, 3'd2, 32'h3FFE, 32'h0,        32'h00001234, 1'b0});

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {32'd0, ready_a}, 33'd0);
    check("rst_rvalid", {32'd0, rvalid_a}, 33'd0);
    check("rst_fault", {32'd0, fault_a}, 33'd0);
    check("rst_rdata", {1'b0, rdata_a}, 33'd0);
    check("rst_busy", {32'd0, busy_a}, 33'd1);
    reset_a = 1'b0;
    reset_b = 1'b0;
    #1 check("clear_busy", {32'd0, busy_a}, 33'd1);
    wait_ready_a(16);

    for (int i = 0; i < tbl_a.size(); i++) access_a(tbl_a[i], i);

    // reset while a store is in WAIT: abandoned, no rvalid, no write
    n = 0;
    while (!ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    we = 1'b1; size = 3'd0; addr = 32'h08; wdata = 32'hDEADBEEF; req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    check("wait_state", {31'd0, dbg_state_a}, 33'd2);
    reset_a = 1'b1;
    #1 check("rst_wait_ready", {32'd0, ready_a}, 33'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst_wait_rvalid%0d", i), {32'd0, rvalid_a}, 33'd0);
    end
    reset_a = 1'b0;
    wait_ready_a(16);
    access_a('{1'b0, 3'd0, 32'h08, 32'h0, 32'h0, 1'b0}, 100);
    access_a('{1'b0, 3'd0, 32'h20, 32'h0, 32'h0, 1'b0}, 101);

    // dut_b back-to-back with req held high
    n = 0;
    while (!ready_b && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("b_ready_after_clear", {32'd0, ready_b}, 33'd1);
    req_b = 1'b1;
    for (int i = 0; i < tbl_b.size(); i++) begin
      check($sformatf("b_ready_idle%0d", i), {31'd0, ready_b, rvalid_b}, 33'b10);
      we = tbl_b[i].w; size = tbl_b[i].sz; addr = tbl_b[i].ad; wdata = tbl_b[i].wd; pc = pc + 32'd4;
      exp_q_b.push_back({tbl_b[i].ef, tbl_b[i].er});
      tag_q_b.push_back(i);
      @(negedge clk);
      check($sformatf("b_ready_resp%0d", i), {31'd0, ready_b, rvalid_b}, 33'b01);
      @(negedge clk);
    end
    req_b = 1'b0;

    repeat (4) @(negedge clk);
    check("a_queue_drained", 33'(exp_q_a.size()), 33'd0);
    check("b_queue_drained", 33'(exp_q_b.size()), 33'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
